// File: rtl/neo_video_pkg.sv
// Shared fix-layer definitions: field widths, fetch FSM states, S ROM address builder.
package neo_video_pkg;

  localparam int FIX_TILE_W  = 12;
  localparam int FIX_PAL_W   = 4;
  localparam int FIX_LINE_W  = 3;
  localparam int SROM_BANK_W = 2;
  localparam int SROM_ADDR_W = SROM_BANK_W + FIX_TILE_W + FIX_LINE_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } fix_state_e;

  typedef struct packed {
    logic [FIX_PAL_W-1:0] pal;
    logic [31:0]          data;
  } fix_pix_t;

  // Each tile line is one 32-bit word; non-CMC carts only ever see bank 0.
  function automatic logic [SROM_ADDR_W-1:0] fix_srom_addr(
    input logic                   cmc_en,
    input logic [SROM_BANK_W-1:0] bank,
    input logic [FIX_TILE_W-1:0]  tile,
    input logic [FIX_LINE_W-1:0]  line
  );
    logic [SROM_BANK_W-1:0] eff_bank;
    eff_bank = cmc_en ? bank : '0;
    return {eff_bank, tile, line, 2'b00};
  endfunction

endpackage

// File: rtl/neo_fix_fifo.sv
// Synchronous FIFO with registered head; head is visible the cycle after a push into empty.
// No internal backpressure: the producer must check count, simultaneous push/pop on full is allowed.
module neo_fix_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 36
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         flush,
  input  logic                         push,
  input  logic [DW-1:0]                push_dat,
  input  logic                         pop,
  output logic                         head_vld,
  output logic [DW-1:0]                head_dat,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [$clog2(DEPTH):0] FULL_CNT = ($clog2(DEPTH) + 1)'(DEPTH);

  logic [DW-1:0]          mem [DEPTH];
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_nxt;
  logic [$clog2(DEPTH):0] cnt_nxt;
  logic                   do_pop;

  assign do_pop = pop && head_vld;
  assign rd_nxt = do_pop ? rd_ptr + 1'b1 : rd_ptr;

  always_comb begin
    cnt_nxt = count;
    if (push && !do_pop)
      cnt_nxt = count + 1'b1;
    else if (!push && do_pop)
      cnt_nxt = count - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      head_vld <= 1'b0;
      head_dat <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr   <= rd_nxt;
      count    <= cnt_nxt;
      head_vld <= (cnt_nxt != '0);
      // The word landing in the next head slot is not in mem yet; bypass it.
      head_dat <= (push && (wr_ptr == rd_nxt)) ? push_dat : mem[rd_nxt];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && !flush)
      assert (!(push && !do_pop && (count == FULL_CNT)));
  end

endmodule

// File: rtl/neo_fix_fetch.sv
// Fix-layer S ROM tile-line fetcher: FIX_REQ to MEM_REQ in 2 cycles, pixel word visible 1 cycle after MEM_ACK.
// Holds one pending entry; stalls fetches while the pixel FIFO is full and drops (OVF) when the slot is taken.
module neo_fix_fetch
  import neo_video_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 19
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   CMC_EN,
  input  logic                   FIX_REQ,
  input  logic [FIX_TILE_W-1:0]  FIX_TILE,
  input  logic [FIX_PAL_W-1:0]   FIX_PAL,
  input  logic [FIX_LINE_W-1:0]  FIX_LINE,
  input  logic [SROM_BANK_W-1:0] FIX_BANK,
  input  logic                   LINE_START,
  output logic                   MEM_REQ,
  output logic [ADDR_W-1:0]      MEM_ADDR,
  input  logic                   MEM_ACK,
  input  logic [31:0]            MEM_DATA,
  output logic                   PIX_VALID,
  output logic [31:0]            PIX_DATA,
  output logic [FIX_PAL_W-1:0]   PIX_PAL,
  input  logic                   PIX_POP,
  output logic                   OVF
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  fix_state_e           state;
  fix_state_e           state_nxt;
  logic                 pend_vld;
  logic [ADDR_W-1:0]    pend_addr;
  logic [FIX_PAL_W-1:0] pend_pal;
  logic [FIX_PAL_W-1:0] req_pal;
  logic                 go_issue;
  logic                 slot_free;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [CW-1:0]        fifo_cnt;
  fix_pix_t             push_word;
  fix_pix_t             head_word;

  // Nothing is in flight while IDLE, so the current count alone decides room.
  assign go_issue  = (state == IDLE) && pend_vld && (fifo_cnt != FULL_CNT) && !LINE_START;
  assign slot_free = !pend_vld || go_issue || LINE_START;
  assign fifo_push = (state == ISSUE) && MEM_ACK && !LINE_START;
  assign fifo_pop  = PIX_POP && PIX_VALID;

  always_ff @(posedge CLK) begin
    if (RESET)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    MEM_REQ   = 1'b0;
    case (state)
      IDLE: begin
        if (go_issue)
          state_nxt = ISSUE;
      end
      ISSUE: begin
        MEM_REQ = 1'b1;
        if (MEM_ACK)
          state_nxt = IDLE;
        else if (LINE_START)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        MEM_REQ = 1'b1;
        if (MEM_ACK)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      pend_pal  <= '0;
      MEM_ADDR  <= '0;
      req_pal   <= '0;
      OVF       <= 1'b0;
    end else begin
      if (go_issue) begin
        MEM_ADDR <= pend_addr;
        req_pal  <= pend_pal;
      end
      if (FIX_REQ && slot_free) begin
        pend_vld  <= 1'b1;
        pend_addr <= ADDR_W'(fix_srom_addr(CMC_EN, FIX_BANK, FIX_TILE, FIX_LINE));
        pend_pal  <= FIX_PAL;
      end else if (go_issue || LINE_START) begin
        pend_vld <= 1'b0;
      end
      if (LINE_START)
        OVF <= 1'b0;
      else if (FIX_REQ && !slot_free)
        OVF <= 1'b1;
    end
  end

  assign push_word = '{pal: req_pal, data: MEM_DATA};

  neo_fix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    ($bits(fix_pix_t))
  ) u_fifo (
    .CLK      (CLK),
    .RESET    (RESET),
    .flush    (LINE_START),
    .push     (fifo_push),
    .push_dat (push_word),
    .pop      (fifo_pop),
    .head_vld (PIX_VALID),
    .head_dat (head_word),
    .count    (fifo_cnt)
  );

  assign PIX_DATA = head_word.data;
  assign PIX_PAL  = head_word.pal;

endmodule

// File: tb/tb_neo_fix_fetch.sv
// Directed bench for neo_fix_fetch with a queue-based reference model checked every cycle.
module tb_neo_fix_fetch;

  localparam int DEPTH = 2;
  localparam int AW    = 19;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          CMC_EN = 1'b0;
  logic          FIX_REQ = 1'b0;
  logic [11:0]   FIX_TILE = '0;
  logic [3:0]    FIX_PAL = '0;
  logic [2:0]    FIX_LINE = '0;
  logic [1:0]    FIX_BANK = '0;
  logic          LINE_START = 1'b0;
  logic          MEM_REQ;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_ACK = 1'b0;
  logic [31:0]   MEM_DATA = '0;
  logic          PIX_VALID;
  logic [31:0]   PIX_DATA;
  logic [3:0]    PIX_PAL;
  logic          PIX_POP = 1'b0;
  logic          OVF;

  neo_fix_fetch #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .CLK(CLK), .RESET(RESET), .CMC_EN(CMC_EN), .FIX_REQ(FIX_REQ),
    .FIX_TILE(FIX_TILE), .FIX_PAL(FIX_PAL), .FIX_LINE(FIX_LINE), .FIX_BANK(FIX_BANK),
    .LINE_START(LINE_START), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK),
    .MEM_DATA(MEM_DATA), .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA), .PIX_PAL(PIX_PAL),
    .PIX_POP(PIX_POP), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  typedef struct { logic [31:0] d; logic [3:0] p; } word_t;
  typedef struct { logic [18:0] a; logic [3:0] p; } req_t;
  word_t m_fifo[$];
  req_t  m_pend[$];
  req_t  m_fly = '{19'd0, 4'd0};
  int    m_phase = 0;    // 0: no transaction, 1: fetch outstanding, 2: flushed fetch outstanding
  bit    m_ovf = 1'b0;
  bit    chk_on = 1'b0;

  // Byte address: 128 KB per bank, 32 bytes per tile, 4 bytes per line.
  function automatic logic [18:0] exp_addr(bit cmc, logic [1:0] bank, logic [11:0] tile, logic [2:0] line);
    logic [18:0] a;
    a = 19'(cmc ? bank : 2'd0) * 19'd131072 + 19'(tile) * 19'd32 + 19'(line) * 19'd4;
    return a;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin : model
    bit pop_now, go_now, ack_now, free_now;
    if (RESET) begin
      m_fifo.delete();
      m_pend.delete();
      m_phase = 0;
      m_ovf   = 1'b0;
    end else begin
      pop_now  = PIX_POP && (m_fifo.size() > 0);
      go_now   = (m_phase == 0) && (m_pend.size() > 0) && (m_fifo.size() < DEPTH) && !LINE_START;
      ack_now  = (m_phase == 1) && MEM_ACK;
      free_now = (m_pend.size() == 0) || go_now || LINE_START;
      if (LINE_START) m_fifo.delete();
      else begin
        if (pop_now) void'(m_fifo.pop_front());
        if (ack_now) m_fifo.push_back('{MEM_DATA, m_fly.p});
      end
      if (m_phase != 0) begin
        if (MEM_ACK) m_phase = 0;
        else if (LINE_START) m_phase = 2;
      end else if (go_now) begin
        m_phase = 1;
        m_fly   = m_pend[0];
      end
      if (go_now || LINE_START) m_pend.delete();
      if (LINE_START) m_ovf = 1'b0;
      if (FIX_REQ) begin
        if (free_now) m_pend.push_back('{exp_addr(CMC_EN, FIX_BANK, FIX_TILE, FIX_LINE), FIX_PAL});
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("pix_valid", 32'(PIX_VALID), 32'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) begin
        chk("pix_data", PIX_DATA, m_fifo[0].d);
        chk("pix_pal", 32'(PIX_PAL), 32'(m_fifo[0].p));
      end
      chk("ovf", 32'(OVF), 32'(m_ovf));
      chk("mem_req", 32'(MEM_REQ), 32'(m_phase != 0));
      if (m_phase != 0) chk("mem_addr", 32'(MEM_ADDR), 32'(m_fly.a));
    end
  end

  // All tasks start and end on a falling edge.
  task automatic fix_req(bit cmc, logic [1:0] bank, logic [11:0] tile, logic [3:0] pal, logic [2:0] line);
    CMC_EN = cmc; FIX_BANK = bank; FIX_TILE = tile; FIX_PAL = pal; FIX_LINE = line;
    FIX_REQ = 1'b1;
    @(negedge CLK);
    FIX_REQ = 1'b0;
  endtask

  task automatic wait_req(string nm);
    int n = 0;
    while (!MEM_REQ && n < 20) begin
      @(negedge CLK);
      n++;
    end
    tests++;
    if (!MEM_REQ) begin
      fails++;
      $display("FAIL %s: MEM_REQ got 0 required 1 within 20 cycles", nm);
    end
  endtask

  task automatic ack(int lat, logic [31:0] data);
    repeat (lat) @(negedge CLK);
    MEM_ACK = 1'b1; MEM_DATA = data;
    @(negedge CLK);
    MEM_ACK = 1'b0;
  endtask

  task automatic pop1();
    PIX_POP = 1'b1;
    @(negedge CLK);
    PIX_POP = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (PIX_VALID && n < 10) begin
      PIX_POP = 1'b1;
      @(negedge CLK);
      n++;
    end
    PIX_POP = 1'b0;
  endtask

  task automatic line_start();
    LINE_START = 1'b1;
    @(negedge CLK);
    LINE_START = 1'b0;
  endtask

  task automatic fetch(bit cmc, logic [1:0] bank, logic [11:0] tile, logic [3:0] pal,
                       logic [2:0] line, logic [31:0] data, int lat);
    fix_req(cmc, bank, tile, pal, line);
    wait_req("fetch_req");
    ack(lat, data);
  endtask

  initial begin
    @(negedge CLK);
    chk_on = 1'b1;
    chk("rst_mem_req", 32'(MEM_REQ), 32'd0);
    chk("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
    chk("rst_pix_valid", 32'(PIX_VALID), 32'd0);
    chk("rst_pix_data", PIX_DATA, 32'd0);
    chk("rst_pix_pal", 32'(PIX_PAL), 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    // Stray ack while idle must not push anything.
    ack(0, 32'h5555AAAA);
    chk("stray_ack", 32'(PIX_VALID), 32'd0);

    // Single fetch, CMC bank 2.
    fix_req(1'b1, 2'd2, 12'h123, 4'd7, 3'd5);
    chk("req_not_yet", 32'(MEM_REQ), 32'd0);
    @(negedge CLK);
    chk("req_2cyc", 32'(MEM_REQ), 32'd1);
    chk("addr_single", 32'(MEM_ADDR), 32'h42474);
    ack(0, 32'hDEADBEEF);
    chk("single_vld", 32'(PIX_VALID), 32'd1);
    chk("single_data", PIX_DATA, 32'hDEADBEEF);
    chk("single_pal", 32'(PIX_PAL), 32'd7);
    chk("single_req_drop", 32'(MEM_REQ), 32'd0);
    pop1();

    // Bank forced to 0 without CMC.
    fix_req(1'b0, 2'd3, 12'hFFF, 4'd1, 3'd7);
    wait_req("bank_dis_req");
    chk("addr_bank_dis", 32'(MEM_ADDR), 32'h1FFFC);
    ack(1, 32'h01234567);
    drain();

    // Backpressure: two words fill the FIFO, third waits, fourth overflows.
    fetch(1'b1, 2'd0, 12'h010, 4'd2, 3'd0, 32'hA0A0A0A0, 3);
    fetch(1'b1, 2'd0, 12'h011, 4'd2, 3'd1, 32'hB0B0B0B0, 3);
    fix_req(1'b1, 2'd1, 12'h055, 4'd3, 3'd2);
    for (int i = 0; i < 6; i++) begin
      chk("bp_held", 32'(MEM_REQ), 32'd0);
      @(negedge CLK);
    end
    fix_req(1'b1, 2'd1, 12'h056, 4'd3, 3'd2);
    chk("bp_ovf", 32'(OVF), 32'd1);
    chk("bp_head", PIX_DATA, 32'hA0A0A0A0);
    pop1();
    wait_req("bp_third_req");
    chk("bp_third_addr", 32'(MEM_ADDR), 32'h20AA8);
    ack(3, 32'hC0C0C0C0);
    chk("bp_order", PIX_DATA, 32'hB0B0B0B0);
    drain();
    repeat (3) begin
      chk("bp_fourth_dropped", 32'(MEM_REQ), 32'd0);
      @(negedge CLK);
    end
    line_start();
    chk("bp_ovf_clr", 32'(OVF), 32'd0);

    // LINE_START while a fetch is outstanding.
    fetch(1'b0, 2'd0, 12'h1FF, 4'd4, 3'd3, 32'h11111111, 0);
    fix_req(1'b0, 2'd0, 12'h200, 4'd5, 3'd0);
    wait_req("ls_req");
    fix_req(1'b0, 2'd0, 12'h201, 4'd5, 3'd0);
    fix_req(1'b0, 2'd0, 12'h202, 4'd5, 3'd0);
    chk("ls_ovf_set", 32'(OVF), 32'd1);
    line_start();
    chk("ls_req_held", 32'(MEM_REQ), 32'd1);
    chk("ls_flushed", 32'(PIX_VALID), 32'd0);
    chk("ls_ovf_clr", 32'(OVF), 32'd0);
    repeat (2) @(negedge CLK);
    chk("ls_req_held2", 32'(MEM_REQ), 32'd1);
    ack(0, 32'hBAD0BAD0);
    chk("ls_discard", 32'(PIX_VALID), 32'd0);
    chk("ls_req_done", 32'(MEM_REQ), 32'd0);
    repeat (3) begin
      chk("ls_slot_flushed", 32'(MEM_REQ), 32'd0);
      @(negedge CLK);
    end

    // LINE_START and FIX_REQ together while the slot is full.
    fix_req(1'b0, 2'd0, 12'h300, 4'd6, 3'd0);
    wait_req("sim_req");
    fix_req(1'b0, 2'd0, 12'h301, 4'd6, 3'd0);
    LINE_START = 1'b1;
    fix_req(1'b0, 2'd0, 12'h001, 4'd9, 3'd0);
    LINE_START = 1'b0;
    chk("sim_ovf", 32'(OVF), 32'd0);
    ack(1, 32'hDEAD0000);
    wait_req("sim_new_req");
    chk("sim_addr", 32'(MEM_ADDR), 32'h00020);
    ack(0, 32'h76543210);
    chk("sim_data", PIX_DATA, 32'h76543210);
    chk("sim_pal", 32'(PIX_PAL), 32'd9);
    repeat (3) begin
      chk("sim_old_gone", 32'(MEM_REQ), 32'd0);
      @(negedge CLK);
    end
    drain();

    // Push and pop in the same cycle, then order of three consecutive words.
    fetch(1'b1, 2'd3, 12'h400, 4'd1, 3'd1, 32'hAAAA0001, 0);
    fix_req(1'b1, 2'd3, 12'h401, 4'd2, 3'd1);
    wait_req("pp_req");
    MEM_ACK = 1'b1; MEM_DATA = 32'hAAAA0002; PIX_POP = 1'b1;
    @(negedge CLK);
    MEM_ACK = 1'b0; PIX_POP = 1'b0;
    chk("pp_valid", 32'(PIX_VALID), 32'd1);
    chk("pp_w2", PIX_DATA, 32'hAAAA0002);
    fetch(1'b1, 2'd3, 12'h402, 4'd3, 3'd1, 32'hAAAA0003, 2);
    chk("pp_w2_still", PIX_DATA, 32'hAAAA0002);
    pop1();
    chk("pp_w3", PIX_DATA, 32'hAAAA0003);
    chk("pp_w3_pal", 32'(PIX_PAL), 32'd3);
    pop1();
    chk("pp_empty", 32'(PIX_VALID), 32'd0);

    // Reset in the middle of a fetch drops MEM_REQ.
    fix_req(1'b1, 2'd1, 12'h500, 4'd8, 3'd4);
    wait_req("rst_mid_req");
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst_mid_req_drop", 32'(MEM_REQ), 32'd0);
    chk("rst_mid_addr", 32'(MEM_ADDR), 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running required done");
    $fatal(1, "timeout");
  end

endmodule
